// File: rtl/imem_pkg.sv
// Shared definitions for the synchronous instruction memory.
// Contents: response fault codes, fetch FSM state type, default fill word and
// instruction field widths (6 opcode | 4 Rd | 4 Rs | 4 Rt | 14 Imm).
package imem_pkg;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;
    localparam logic [1:0] FAULT_PARITY   = 2'b11;

    typedef enum logic [0:0] {
        CLEAR,
        RUN
    } state_e;

    localparam logic [31:0] FILL_WORD_DEFAULT = 32'hFFFF_FFFF;

    localparam int unsigned OPC_W = 6;
    localparam int unsigned REG_W = 4;
    localparam int unsigned IMM_W = 14;

endpackage

// File: rtl/imem_sync_ram.sv
// Synchronous read-first memory array: one write port and one read port.
// No reset; contents are initialised by whoever drives the write port.
// Ports:
//   clk          clock
//   we/waddr/wdata  write enable, word index, data (written on the rising edge)
//   re/raddr     read enable and word index; rdata updates only when re is high
//   rdata        registered read data (old contents on a same-edge write)
module imem_sync_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Both ports use non-blocking updates, so a same-edge read sees old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_sync_fetch.sv
// Synchronous-read instruction memory with a valid/ready fetch handshake,
// branch flush, program-load write port, post-reset clear sweep and
// alignment / range fault reporting.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity, adds par_inject).
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   req_valid/req_addr   fetch request and byte address; req_ready accepts it
//   flush                drops the in-flight response, blocks acceptance this cycle
//   resp_valid/resp_ready  response handshake (resp_ready low = stall)
//   resp_instr/resp_addr/resp_fault  response payload (fault 00/01/10/11)
//   prog_we/prog_addr/prog_data  program-load write (ignored during the sweep)
//   par_inject           (IMEM_PARITY_EN only) flip stored parity of a write
//   busy                 clear sweep in progress
module imem_sync_fetch
    import imem_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 1024,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(FILL_WORD_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     req_ready,
    input  logic                     flush,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_W-1:0]        resp_instr,
    output logic [ADDR_W-1:0]        resp_addr,
    output logic [1:0]               resp_fault,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [DATA_W-1:0]        prog_data,
`ifdef IMEM_PARITY_EN
    input  logic                     par_inject,
`endif
    output logic                     busy
);

    localparam int unsigned AW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
    logic [1:0]        fault_q, fault_d;
    logic              hit_q, hit_d;  // response payload comes from the array

    logic              accept, misalign, range_err, par_err;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [DATA_W-1:0] wr_word;
    logic [MEM_W-1:0]  ram_wdata, ram_rdata;

    // Write port is owned by the sweep while clearing, by program load in RUN.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ram_we    = 1'b0;
        ram_waddr = prog_addr;
        wr_word   = prog_data;
        unique case (state_q)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
                wr_word   = FILL_WORD;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ram_we = prog_we;
            end
            default: state_d = CLEAR;
        endcase
    end

`ifdef IMEM_PARITY_EN
    assign ram_wdata = {(^wr_word) ^ (par_inject && (state_q == RUN)), wr_word};
`else
    assign ram_wdata = wr_word;
`endif

    assign busy      = (state_q == CLEAR);
    assign req_ready = (state_q == RUN) && !flush && (!resp_valid_q || resp_ready);
    assign accept    = req_valid && req_ready;
    assign misalign  = |req_addr[1:0];

    if (AW + 2 < ADDR_W) begin : g_range
        assign range_err = |req_addr[ADDR_W-1:AW+2];
    end else begin : g_no_range
        assign range_err = 1'b0;
    end

    // Flush beats acceptance; acceptance beats a plain consume.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_addr_d  = resp_addr_q;
        fault_d      = fault_q;
        hit_d        = hit_q;
        if (flush) begin
            resp_valid_d = 1'b0;
        end else if (accept) begin
            resp_valid_d = 1'b1;
            resp_addr_d  = req_addr;
            hit_d        = !misalign && !range_err;
            fault_d      = misalign  ? FAULT_MISALIGN :
                           range_err ? FAULT_RANGE    : FAULT_OK;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= CLEAR;
            clr_cnt_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_addr_q  <= '0;
            fault_q      <= FAULT_OK;
            hit_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_addr_q  <= resp_addr_d;
            fault_q      <= fault_d;
            hit_q        <= hit_d;
        end
    end

    // Read data register only moves on accept, so it holds through stalls.
    imem_sync_ram #(
        .DEPTH(DEPTH),
        .WIDTH(MEM_W),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .re   (accept),
        .raddr(req_addr[AW+1:2]),
        .rdata(ram_rdata)
    );

`ifdef IMEM_PARITY_EN
    assign par_err = hit_q && (^ram_rdata);
`else
    assign par_err = 1'b0;
`endif

    assign resp_valid = resp_valid_q;
    assign resp_addr  = resp_addr_q;
    assign resp_instr = (hit_q && !par_err) ? ram_rdata[DATA_W-1:0] : FILL_WORD;
    assign resp_fault = par_err ? FAULT_PARITY : fault_q;

endmodule

// File: tb/tb_imem_sync_fetch.sv
module tb_imem_sync_fetch;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] F = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, flush, resp_valid, resp_ready, prog_we, busy;
    logic [31:0] req_addr, resp_instr, resp_addr, prog_data;
    logic [1:0]  resp_fault;
    logic [3:0]  prog_addr;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    imem_sync_fetch #(
        .ADDR_W(32),
        .DATA_W(32),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .flush     (flush),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_instr(resp_instr),
        .resp_addr (resp_addr),
        .resp_fault(resp_fault),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .busy      (busy)
    );

    typedef struct {
        logic        rv;
        logic [31:0] addr;
        logic        rr;
        logic        fl;
        logic        pwe;
        logic [3:0]  pa;
        logic [31:0] pd;
        logic        e_rdy;
        logic        e_rv;
        logic [31:0] e_instr;
        logic [31:0] e_addr;
        logic [1:0]  e_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [3:0] rt,
                                        input logic [13:0] imm);
        return {op, rd, rs, rt, imm};
    endfunction

    function automatic vec_t mk(input logic rv, input logic [31:0] addr, input logic rr,
                                input logic fl, input logic pwe, input logic [3:0] pa,
                                input logic [31:0] pd, input logic e_rdy, input logic e_rv,
                                input logic [31:0] e_instr, input logic [31:0] e_addr,
                                input logic [1:0] e_fault);
        vec_t v;
        v.rv = rv; v.addr = addr; v.rr = rr; v.fl = fl; v.pwe = pwe; v.pa = pa; v.pd = pd;
        v.e_rdy = e_rdy; v.e_rv = e_rv; v.e_instr = e_instr; v.e_addr = e_addr;
        v.e_fault = e_fault;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Called just after a negedge; returns just after the following negedge.
    task automatic apply(input int idx, input vec_t v);
        req_valid  = v.rv;
        req_addr   = v.addr;
        resp_ready = v.rr;
        flush      = v.fl;
        prog_we    = v.pwe;
        prog_addr  = v.pa;
        prog_data  = v.pd;
        #1;
        chk($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'(v.e_rdy));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d resp_valid", idx), 32'(resp_valid), 32'(v.e_rv));
        chk($sformatf("v%0d resp_instr", idx), resp_instr, v.e_instr);
        chk($sformatf("v%0d resp_addr", idx), resp_addr, v.e_addr);
        chk($sformatf("v%0d resp_fault", idx), 32'(resp_fault), 32'(v.e_fault));
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_addr = 0; resp_ready = 1; flush = 0;
        prog_we = 0; prog_addr = 0; prog_data = 0;
    endtask

    // Releases reset at the current negedge and counts busy cycles.
    task automatic sweep(input string tag);
        int n = 0;
        reset = 0;
        #1;
        while (busy === 1'b1 && n < 100) begin
            chk($sformatf("%s req_ready low in sweep", tag), 32'(req_ready), 32'd0);
            n++;
            @(negedge clk);
            #1;
        end
        chk($sformatf("%s busy cycles", tag), 32'(n), 32'(DEPTH));
        @(negedge clk);
    endtask

    logic [31:0] w0, w1, w2, w1n;

    initial begin
        w0  = enc(6'h08, 4'd1, 4'd0, 4'd0, 14'd5);   // ADDI R1,R0,5
        w1  = enc(6'h08, 4'd2, 4'd0, 4'd0, 14'd10);  // ADDI R2,R0,10
        w2  = enc(6'h00, 4'd3, 4'd1, 4'd2, 14'd0);   // ADD  R3,R1,R2
        w1n = enc(6'h08, 4'd2, 4'd0, 4'd0, 14'd99);

        //           rv addr   rr fl pwe pa  pd   | rdy rv instr addr  fault
        vecs.push_back(mk(1, 32'h0,  1, 0, 0, 4'd0, 0,   1, 1, F,   32'h0,  2'b00));
        vecs.push_back(mk(0, 32'h0,  1, 0, 1, 4'd0, w0,  1, 0, F,   32'h0,  2'b00));
        vecs.push_back(mk(0, 32'h0,  1, 0, 1, 4'd1, w1,  1, 0, F,   32'h0,  2'b00));
        vecs.push_back(mk(0, 32'h0,  1, 0, 1, 4'd2, w2,  1, 0, F,   32'h0,  2'b00));
        // back-to-back fetches
        vecs.push_back(mk(1, 32'h0,  1, 0, 0, 4'd0, 0,   1, 1, w0,  32'h0,  2'b00));
        vecs.push_back(mk(1, 32'h4,  1, 0, 0, 4'd0, 0,   1, 1, w1,  32'h4,  2'b00));
        vecs.push_back(mk(1, 32'h8,  1, 0, 0, 4'd0, 0,   1, 1, w2,  32'h8,  2'b00));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 4'd0, 0,   1, 0, w2,  32'h8,  2'b00));
        // stall for three cycles then release
        vecs.push_back(mk(1, 32'h4,  1, 0, 0, 4'd0, 0,   1, 1, w1,  32'h4,  2'b00));
        vecs.push_back(mk(1, 32'h8,  0, 0, 0, 4'd0, 0,   0, 1, w1,  32'h4,  2'b00));
        vecs.push_back(mk(1, 32'h8,  0, 0, 0, 4'd0, 0,   0, 1, w1,  32'h4,  2'b00));
        vecs.push_back(mk(1, 32'h8,  0, 0, 0, 4'd0, 0,   0, 1, w1,  32'h4,  2'b00));
        vecs.push_back(mk(1, 32'h8,  1, 0, 0, 4'd0, 0,   1, 1, w2,  32'h8,  2'b00));
        // flush while 0x8 is pending; same-cycle request not taken
        vecs.push_back(mk(1, 32'hC,  0, 1, 0, 4'd0, 0,   0, 0, w2,  32'h8,  2'b00));
        vecs.push_back(mk(1, 32'hC,  1, 0, 0, 4'd0, 0,   1, 1, F,   32'hC,  2'b00));
        // faults and last in-range word
        vecs.push_back(mk(1, 32'h6,  1, 0, 0, 4'd0, 0,   1, 1, F,   32'h6,  2'b01));
        vecs.push_back(mk(1, 32'h40, 1, 0, 0, 4'd0, 0,   1, 1, F,   32'h40, 2'b10));
        vecs.push_back(mk(1, 32'h41, 1, 0, 0, 4'd0, 0,   1, 1, F,   32'h41, 2'b01));
        vecs.push_back(mk(1, 32'h3C, 1, 0, 0, 4'd0, 0,   1, 1, F,   32'h3C, 2'b00));
        // read-first on same-cycle write, new data afterwards
        vecs.push_back(mk(1, 32'h4,  1, 0, 1, 4'd1, w1n, 1, 1, w1,  32'h4,  2'b00));
        vecs.push_back(mk(1, 32'h4,  1, 0, 0, 4'd0, 0,   1, 1, w1n, 32'h4,  2'b00));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 4'd0, 0,   1, 0, w1n, 32'h4,  2'b00));

        idle_inputs();
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_instr", resp_instr, F);
        chk("reset resp_addr", resp_addr, 32'h0);
        chk("reset resp_fault", 32'(resp_fault), 32'd0);
        chk("reset busy", 32'(busy), 32'd1);
        chk("reset req_ready", 32'(req_ready), 32'd0);

        // prog_we during the sweep must be ignored
        prog_we = 1; prog_addr = 4'd5; prog_data = 32'h1234_5678;
        sweep("first");
        idle_inputs();

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // reset mid-fetch drops the response; reset mid-sweep restarts the sweep
        req_valid = 1; req_addr = 32'h0;
        @(posedge clk);
        #1;
        chk("pre-reset resp_valid", 32'(resp_valid), 32'd1);
        reset = 1;
        #1;
        chk("mid-fetch reset resp_valid", 32'(resp_valid), 32'd0);
        chk("mid-fetch reset busy", 32'(busy), 32'd1);
        idle_inputs();
        @(negedge clk);
        reset = 0;
        repeat (5) @(negedge clk);
        chk("mid-sweep busy", 32'(busy), 32'd1);
        reset = 1;
        @(negedge clk);
        sweep("restart");

        // sweep must have re-cleared previously programmed words
        apply(100, mk(1, 32'h0, 1, 0, 0, 4'd0, 0, 1, 1, F, 32'h0, 2'b00));
        apply(101, mk(1, 32'h14, 1, 0, 0, 4'd0, 0, 1, 1, F, 32'h14, 2'b00));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
